mem_stage_pipe: RTL and testbench
=================================

Name: mem_stage_pipe

Overview:
- Parametrised successor to the CPU's memory-access pipeline stage, sitting between EX/MEM and WB.
- Replaces the fixed 32-bit, zero-wait, combinational memory path with four things:
  - a registered request/acknowledge memory port tolerating variable latency;
  - byte/half/word/doubleword sized accesses with lane steering and sign/zero extension;
  - upstream stall generation;
  - registered MEM/WB outputs plus branch redirect.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64
ADDR_W, 32, memory address width
RD_W, 5, destination register index width

Ports:
CLK  in  1  clock, all state on rising edge
RESET  in  1  synchronous reset, active-low (0 = reset)
ex_valid  in  1  EX/MEM bundle valid
ex_ready  out  1  stage can accept bundle this cycle
ex_rd  in  RD_W  destination register
ex_alu  in  XLEN  ALU result / effective address
ex_store_data  in  XLEN  store data, unaligned (lane 0)
ex_mem_read  in  1  load
ex_mem_write  in  1  store
ex_size  in  2  0=byte 1=half 2=word 3=dword
ex_unsigned  in  1  zero-extend load
ex_reg_write  in  1  writeback enable
ex_wb_sel  in  2  WB mux select, passed through
ex_pc  in  32  instruction PC, passed through
ex_branch  in  1  branch taken
ex_jaddr  in  32  branch target
mem_req  out  1  memory request
mem_we  out  1  write strobe
mem_addr  out  ADDR_W  request address
mem_wdata  out  XLEN  lane-steered store data
mem_be  out  XLEN/8  byte enables
mem_ack  in  1  request complete; rdata valid on loads
mem_rdata  in  XLEN  raw read word
wb_valid  out  1  MEM/WB bundle valid, one-cycle pulse
wb_rd  out  RD_W  destination register
wb_mem_data  out  XLEN  extended load data
wb_alu  out  XLEN  ALU result pass-through
wb_reg_write  out  1  writeback enable
wb_wb_sel  out  2  WB select
wb_pc  out  32  PC pass-through
wb_trap  out  1  misaligned access (feature only, else tied 0)
branch  out  1  redirect pulse
jaddr  out  32  redirect target
stall  out  1  ex_valid & ~ex_ready

Behaviour:
- Reset: when RESET=0 at a rising edge:
  - state goes to IDLE;
  - all outputs clear to 0 (mem_req, wb_valid, branch, wb_trap, every data field);
  - ex_ready=1 once RESET=1.
- FSM IDLE/WAIT:
  - ex_ready = (state==IDLE).
  - Accept occurs when ex_valid & ex_ready.
- Non-memory op accepted:
  - next edge: wb_* load from bundle, wb_mem_data=0, wb_valid=1 for one cycle (latency 1);
  - state stays IDLE.
- Load/store accepted:
  - next edge: mem_req=1 with mem_we, mem_addr=ex_alu[ADDR_W-1:0], mem_wdata, mem_be registered; state moves to WAIT.
  - All request signals hold stable until mem_ack is sampled 1.
  - On the ack edge: mem_req=0, wb_valid=1 with bundle fields held from acceptance, state returns to IDLE.
  - Minimum load/store latency is 2 cycles from accept to wb_valid.
- mem_ack while IDLE, or in the same cycle the request is first raised: ignored.
- Back-to-back: a new bundle may be accepted on the same edge wb_valid rises (ex_ready=1 in IDLE).
- Lanes: L = log2(XLEN/8); lane offset o = ex_alu[L-1:0].
  - Byte enables: byte = 1<<o; half = 3<<(o&~1); word = 0xF<<(o&~3); dword = all ones.
  - When XLEN=32, size 3 is treated as word.
  - mem_wdata = ex_store_data replicated across all lanes of the access size.
  - Loads: select the lane by o, then sign-extend (ex_unsigned=0) or zero-extend to XLEN.
  - The low address bits the access size does not use are ignored, i.e. the access is forced aligned.
- ex_mem_read and ex_mem_write both 1: treat as store.
- Branch:
  - branch=ex_branch and jaddr=ex_jaddr are registered at accept and pulse exactly one cycle after accept.
  - They are independent of memory latency.
  - branch=0 on all other cycles.
- Reset in WAIT: abandon the access; mem_req=0 and wb_valid=0 after the edge; a later mem_ack is ignored.

Optional Feature:
- Macro MEM_MISALIGN_TRAP_EN. Defined:
  - an access whose offset is not a multiple of its size raises no mem_req;
  - one cycle after accept: wb_valid=1, wb_trap=1, wb_reg_write=0;
  - state stays IDLE.
- Undefined: wb_trap tied 0 and misaligned addresses are force-aligned as above.

Test Plan:
- Reset: hold RESET=0 for 2 cycles while mem_req would otherwise be asserted -> all outputs 0, ex_ready=1 after release.
- ALU op (rd=5, alu=0x1234) -> wb_valid=1 one cycle later, wb_alu=0x1234, wb_rd=5, no mem_req.
- Signed byte load, addr 0x103, rdata 0x80FFFFFF, ack after 3 wait cycles -> wb_mem_data=0xFFFFFF80, stall=1 during WAIT, mem_req stable for 4 cycles.
- Half store, addr 0x102, data 0xABCD -> mem_be=0b1100, mem_wdata=0xABCDABCD, mem_we=1 until ack.
- Branch with load, jaddr 0x40 -> branch pulses at accept+1 while mem_req is still pending; RESET=0 during WAIT -> mem_req=0, wb_valid never asserted.
- MEM_MISALIGN_TRAP_EN defined: word load at 0x102 -> no mem_req, wb_trap=1 and wb_valid=1 at accept+1.

Source files
------------

// File: rtl/mem_stage_pipe.sv
// Memory-access pipeline stage between EX/MEM and WB: variable-latency req/ack port, sized lanes,
// stall, registered MEM/WB bundle and branch redirect. Optional: MEM_MISALIGN_TRAP_EN.
module mem_stage_pipe #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32,
  parameter int RD_W   = 5
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                ex_valid,
  output logic                ex_ready,
  input  logic [RD_W-1:0]     ex_rd,
  input  logic [XLEN-1:0]     ex_alu,
  input  logic [XLEN-1:0]     ex_store_data,
  input  logic                ex_mem_read,
  input  logic                ex_mem_write,
  input  logic [1:0]          ex_size,
  input  logic                ex_unsigned,
  input  logic                ex_reg_write,
  input  logic [1:0]          ex_wb_sel,
  input  logic [31:0]         ex_pc,
  input  logic                ex_branch,
  input  logic [31:0]         ex_jaddr,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [XLEN-1:0]     mem_wdata,
  output logic [XLEN/8-1:0]   mem_be,
  input  logic                mem_ack,
  input  logic [XLEN-1:0]     mem_rdata,
  output logic                wb_valid,
  output logic [RD_W-1:0]     wb_rd,
  output logic [XLEN-1:0]     wb_mem_data,
  output logic [XLEN-1:0]     wb_alu,
  output logic                wb_reg_write,
  output logic [1:0]          wb_wb_sel,
  output logic [31:0]         wb_pc,
  output logic                wb_trap,
  output logic                branch,
  output logic [31:0]         jaddr,
  output logic                stall
);

  localparam int NB = XLEN / 8;
  localparam int L  = $clog2(NB);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_WAIT = 1'b1;

  logic              state;
  logic              accept;
  logic              is_mem;
  logic              trap_hit;
  logic [1:0]        size_eff;
  logic [2:0]        amask;
  logic [2:0]        off3;
  logic [2:0]        base;
  logic [NB-1:0]     be_v;
  logic [XLEN-1:0]   wdata_v;
  logic [ADDR_W-1:0] addr_v;

  // Load-return context captured at accept
  logic [2:0]        ld_base;
  logic [1:0]        ld_size;
  logic              ld_uns;
  logic              ld_is_load;
  logic [XLEN-1:0]   shifted;
  logic [XLEN-1:0]   ld_ext;
  logic              sb;
  logic              fill;
  int                w;

  assign ex_ready = (state == ST_IDLE);
  assign stall    = ex_valid & ~ex_ready;
  assign accept   = ex_valid & ex_ready;
  assign is_mem   = ex_mem_read | ex_mem_write;

  if (ADDR_W <= XLEN) begin : g_addr_trunc
    assign addr_v = ex_alu[ADDR_W-1:0];
  end else begin : g_addr_ext
    assign addr_v = {{(ADDR_W - XLEN){1'b0}}, ex_alu};
  end

  always_comb begin
    size_eff = ex_size;
    if (XLEN == 32 && ex_size == 2'd3) size_eff = 2'd2;
    unique case (size_eff)
      2'd0:    amask = 3'd0;
      2'd1:    amask = 3'd1;
      2'd2:    amask = 3'd3;
      default: amask = 3'd7;
    endcase
    off3        = '0;
    off3[L-1:0] = ex_alu[L-1:0];
    base        = off3 & ~amask;
    // A byte lane belongs to the access iff its aligned group matches the access base.
    be_v = '0;
    for (int i = 0; i < NB; i++) be_v[i] = ((3'(i) & ~amask) == base);
    unique case (size_eff)
      2'd0:    wdata_v = {NB{ex_store_data[7:0]}};
      2'd1:    wdata_v = {(NB / 2){ex_store_data[15:0]}};
      2'd2:    wdata_v = {(XLEN / 32){ex_store_data[31:0]}};
      default: wdata_v = ex_store_data;
    endcase
  end

`ifdef MEM_MISALIGN_TRAP_EN
  assign trap_hit = is_mem & |(off3 & amask);
`else
  assign trap_hit = 1'b0;
`endif

  always_comb begin
    shifted = mem_rdata >> {ld_base, 3'b000};
    w  = XLEN;
    sb = 1'b0;
    unique case (ld_size)
      2'd0:    begin w = 8;    sb = shifted[7];      end
      2'd1:    begin w = 16;   sb = shifted[15];     end
      2'd2:    begin w = 32;   sb = shifted[31];     end
      default: begin w = XLEN; sb = shifted[XLEN-1]; end
    endcase
    fill   = sb & ~ld_uns;
    ld_ext = shifted;
    for (int i = 0; i < XLEN; i++) if (i >= w) ld_ext[i] = fill;
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state        <= ST_IDLE;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_be       <= '0;
      wb_valid     <= 1'b0;
      wb_rd        <= '0;
      wb_mem_data  <= '0;
      wb_alu       <= '0;
      wb_reg_write <= 1'b0;
      wb_wb_sel    <= '0;
      wb_pc        <= '0;
      wb_trap      <= 1'b0;
      branch       <= 1'b0;
      jaddr        <= '0;
      ld_base      <= '0;
      ld_size      <= '0;
      ld_uns       <= 1'b0;
      ld_is_load   <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      wb_trap  <= 1'b0;
      branch   <= 1'b0;
      if (state == ST_WAIT && mem_ack) begin
        state       <= ST_IDLE;
        mem_req     <= 1'b0;
        wb_valid    <= 1'b1;
        wb_mem_data <= ld_is_load ? ld_ext : '0;
      end
      if (accept) begin
        wb_rd        <= ex_rd;
        wb_alu       <= ex_alu;
        wb_reg_write <= ex_reg_write & ~trap_hit;
        wb_wb_sel    <= ex_wb_sel;
        wb_pc        <= ex_pc;
        wb_mem_data  <= '0;
        wb_trap      <= trap_hit;
        branch       <= ex_branch;
        jaddr        <= ex_jaddr;
        if (is_mem && !trap_hit) begin
          state      <= ST_WAIT;
          mem_req    <= 1'b1;
          mem_we     <= ex_mem_write;
          mem_addr   <= addr_v;
          mem_wdata  <= wdata_v;
          mem_be     <= be_v;
          ld_base    <= base;
          ld_size    <= size_eff;
          ld_uns     <= ex_unsigned;
          ld_is_load <= ~ex_mem_write;
        end else begin
          wb_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_pipe.sv
// Directed self-checking bench for mem_stage_pipe (XLEN=32); trap checks when MEM_MISALIGN_TRAP_EN.
module tb_mem_stage_pipe;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        ex_valid, ex_ready;
  logic [4:0]  ex_rd;
  logic [31:0] ex_alu, ex_store_data;
  logic        ex_mem_read, ex_mem_write;
  logic [1:0]  ex_size;
  logic        ex_unsigned, ex_reg_write;
  logic [1:0]  ex_wb_sel;
  logic [31:0] ex_pc;
  logic        ex_branch;
  logic [31:0] ex_jaddr;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_mem_data, wb_alu;
  logic        wb_reg_write;
  logic [1:0]  wb_wb_sel;
  logic [31:0] wb_pc;
  logic        wb_trap, branch;
  logic [31:0] jaddr;
  logic        stall;

  int checks   = 0;
  int failures = 0;

  mem_stage_pipe #(.XLEN(32), .ADDR_W(32), .RD_W(5)) dut (
    .CLK(CLK), .RESET(RESET),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rd(ex_rd), .ex_alu(ex_alu),
    .ex_store_data(ex_store_data), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_size(ex_size), .ex_unsigned(ex_unsigned), .ex_reg_write(ex_reg_write),
    .ex_wb_sel(ex_wb_sel), .ex_pc(ex_pc), .ex_branch(ex_branch), .ex_jaddr(ex_jaddr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_mem_data(wb_mem_data), .wb_alu(wb_alu),
    .wb_reg_write(wb_reg_write), .wb_wb_sel(wb_wb_sel), .wb_pc(wb_pc), .wb_trap(wb_trap),
    .branch(branch), .jaddr(jaddr), .stall(stall)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled and inputs driven 1ns later.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [4:0] rd, input logic [31:0] alu, input logic rd_en,
                       input logic wr_en, input logic [1:0] size, input logic uns,
                       input logic [31:0] sdata);
    ex_valid      = 1'b1;
    ex_rd         = rd;
    ex_alu        = alu;
    ex_mem_read   = rd_en;
    ex_mem_write  = wr_en;
    ex_size       = size;
    ex_unsigned   = uns;
    ex_store_data = sdata;
    ex_reg_write  = 1'b1;
    ex_wb_sel     = 2'd1;
    ex_pc         = 32'h200 + alu;
    ex_branch     = 1'b0;
    ex_jaddr      = 32'h0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    // Reset held while a load would otherwise be accepted
    drive(5'd3, 32'h100, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0);
    tick();
    tick();
    check("rst_mem_req", mem_req, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_branch", branch, 0);
    check("rst_mem_be", mem_be, 0);
    check("rst_wb_alu", wb_alu, 0);
    ex_valid = 1'b0;
    RESET = 1'b1;
    tick();
    check("rst_ex_ready", ex_ready, 1);
    check("rst_mem_req_after", mem_req, 0);

    // ALU op
    drive(5'd5, 32'h1234, 1'b0, 1'b0, 2'd2, 1'b0, 32'h0);
    tick();
    ex_valid = 1'b0;
    check("alu_wb_valid", wb_valid, 1);
    check("alu_wb_alu", wb_alu, 32'h1234);
    check("alu_wb_rd", wb_rd, 5);
    check("alu_wb_pc", wb_pc, 32'h1434);
    check("alu_mem_req", mem_req, 0);
    check("alu_mem_data", wb_mem_data, 0);
    tick();
    check("alu_wb_pulse", wb_valid, 0);

    // Ack while idle is ignored
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("idle_ack_wb_valid", wb_valid, 0);

    // Signed byte load 0x103, ack after 3 wait cycles; an ALU op waits behind it
    drive(5'd9, 32'h103, 1'b1, 1'b0, 2'd0, 1'b0, 32'h0);
    tick();
    drive(5'd7, 32'h77, 1'b0, 1'b0, 2'd2, 1'b0, 32'h0);
    for (int c = 1; c <= 4; c++) begin
      check("lb_mem_req", mem_req, 1);
      check("lb_stall", stall, 1);
      check("lb_wb_valid", wb_valid, 0);
      if (c == 4) begin
        mem_ack   = 1'b1;
        mem_rdata = 32'h80FF_FFFF;
      end
      tick();
    end
    mem_ack = 1'b0;
    check("lb_addr_stale", mem_addr, 32'h103);
    check("lb_be", mem_be, 4'h8);
    check("lb_we", mem_we, 0);
    check("lb_wb_valid_ack", wb_valid, 1);
    check("lb_data", wb_mem_data, 32'hFFFF_FF80);
    check("lb_wb_rd", wb_rd, 9);
    check("lb_mem_req_drop", mem_req, 0);
    check("lb_stall_clear", stall, 0);
    tick();
    ex_valid = 1'b0;
    check("b2b_wb_valid", wb_valid, 1);
    check("b2b_wb_alu", wb_alu, 32'h77);
    check("b2b_wb_rd", wb_rd, 7);
    tick();

    // Unsigned half load at 0x106 with ack already high during accept: latency 2
    drive(5'd4, 32'h106, 1'b1, 1'b0, 2'd1, 1'b1, 32'h0);
    mem_ack   = 1'b1;
    mem_rdata = 32'h8001_1234;
    tick();
    ex_valid = 1'b0;
    check("lhu_first_wb_valid", wb_valid, 0);
    check("lhu_mem_req", mem_req, 1);
    check("lhu_be", mem_be, 4'hC);
    tick();
    mem_ack = 1'b0;
    check("lhu_wb_valid", wb_valid, 1);
    check("lhu_data", wb_mem_data, 32'h0000_8001);
    tick();

    // Half store 0x102 with read+write both set -> store
    drive(5'd2, 32'h102, 1'b1, 1'b1, 2'd1, 1'b0, 32'h0000_ABCD);
    tick();
    ex_valid = 1'b0;
    check("sh_be", mem_be, 4'hC);
    check("sh_wdata", mem_wdata, 32'hABCD_ABCD);
    check("sh_we", mem_we, 1);
    tick();
    check("sh_we_hold", mem_we, 1);
    check("sh_req_hold", mem_req, 1);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("sh_wb_valid", wb_valid, 1);
    check("sh_req_drop", mem_req, 0);
    check("sh_wb_mem_data", wb_mem_data, 0);

    // Byte store lane steering
    drive(5'd2, 32'h101, 1'b0, 1'b1, 2'd0, 1'b0, 32'h1234_565A);
    tick();
    ex_valid = 1'b0;
    check("sb_be", mem_be, 4'h2);
    check("sb_wdata", mem_wdata, 32'h5A5A_5A5A);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;

    // Dword size on 32-bit datapath acts as word
    drive(5'd2, 32'h100, 1'b0, 1'b1, 2'd3, 1'b0, 32'hDEAD_BEEF);
    tick();
    ex_valid = 1'b0;
    check("sd_be", mem_be, 4'hF);
    check("sd_wdata", mem_wdata, 32'hDEAD_BEEF);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    tick();

    // Word load at misaligned 0x102
    drive(5'd6, 32'h102, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0);
    tick();
    ex_valid = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    check("trap_mem_req", mem_req, 0);
    check("trap_wb_valid", wb_valid, 1);
    check("trap_wb_trap", wb_trap, 1);
    check("trap_reg_write", wb_reg_write, 0);
    tick();
    check("trap_pulse", wb_trap, 0);
`else
    check("mis_mem_req", mem_req, 1);
    check("mis_be", mem_be, 4'hF);
    check("mis_trap", wb_trap, 0);
    mem_ack   = 1'b1;
    mem_rdata = 32'hCAFE_F00D;
    tick();
    mem_ack = 1'b0;
    check("mis_data", wb_mem_data, 32'hCAFE_F00D);
    check("mis_trap_ack", wb_trap, 0);
`endif
    tick();

    // Branch with a load, then reset in WAIT
    drive(5'd8, 32'h104, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0);
    ex_branch = 1'b1;
    ex_jaddr  = 32'h40;
    tick();
    ex_valid  = 1'b0;
    ex_branch = 1'b0;
    check("br_branch", branch, 1);
    check("br_jaddr", jaddr, 32'h40);
    check("br_mem_req", mem_req, 1);
    tick();
    check("br_branch_pulse", branch, 0);
    check("br_req_pending", mem_req, 1);
    RESET = 1'b0;
    tick();
    RESET = 1'b1;
    check("wrst_mem_req", mem_req, 0);
    check("wrst_wb_valid", wb_valid, 0);
    check("wrst_ready", ex_ready, 1);
    mem_ack = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      check("wrst_late_ack", wb_valid, 0);
    end
    mem_ack = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
